// File: rtl/seven_bit_operand_loader.sv
// Loads two 7-bit adder operands from a 4-bit switch bank, one segment per
// pushbutton, with per-button synchronization and debouncing.
module seven_bit_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [3:0] Y,
  output logic [6:0] A,
  output logic [6:0] B,
  output logic [3:0] load_mask,
  output logic       operands_valid,
  output logic       load_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    pb_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    db;
  logic [3:0]    press;
  logic [CW-1:0] cnt [4];

  assign pb_raw = {PB4, PB3, PB2, PB1};

  // Two-flop synchronizer per button; only sync2 feeds downstream logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the counter holds how many consecutive edges the synchronized
  // level has disagreed with db; on the DEBOUNCE_CYCLES-th such edge db flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press completes on the edge where db is about to rise.
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = sync2[i] & ~db[i] & (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A          <= '0;
      B          <= '0;
      load_mask  <= '0;
      load_pulse <= 1'b0;
    end else begin
      if (press[0]) A[3:0] <= Y;
      if (press[1]) A[6:4] <= Y[2:0];
      if (press[2]) B[3:0] <= Y;
      if (press[3]) B[6:4] <= Y[2:0];
      // A load after a complete set starts a fresh set from this load alone.
      if (|press) begin
        load_mask <= (operands_valid ? 4'b0000 : load_mask) | press;
      end
      load_pulse <= |press;
    end
  end

  assign operands_valid = &load_mask;

endmodule

// File: tb/tb_seven_bit_operand_loader.sv
// Randomized and directed bench for seven_bit_operand_loader with a
// cycle-level behavioural reference model (DEBOUNCE_CYCLES = 4).
module tb_seven_bit_operand_loader;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic       pb1, pb2, pb3, pb4;
  logic [3:0] y;
  logic [6:0] a, b;
  logic [3:0] load_mask;
  logic       operands_valid;
  logic       load_pulse;

  int checks;
  int passes;
  int obs_pulses;

  seven_bit_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .PB1(pb1), .PB2(pb2), .PB3(pb3), .PB4(pb4),
    .Y(y), .A(a), .B(b), .load_mask(load_mask),
    .operands_valid(operands_valid), .load_pulse(load_pulse)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: synchronized level is the raw level two edges back;
  // a button's debounced level flips after DB consecutive disagreeing edges
  logic [6:0] m_a, m_b;
  logic [3:0] m_mask;
  logic       m_pulse;
  logic [3:0] m_db;
  logic [3:0] raw_hist[$];
  int         m_run[4];
  logic [3:0] m_s, m_pr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a = '0; m_b = '0; m_mask = '0; m_pulse = 1'b0; m_db = '0;
      raw_hist.delete();
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      m_s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 4'b0000;
      raw_hist.push_back({pb4, pb3, pb2, pb1});
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      m_pr = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s[i] != m_db[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DB) begin
          m_db[i]  = m_s[i];
          m_run[i] = 0;
          m_pr[i]  = m_s[i];
        end
      end
      m_pulse = |m_pr;
      if (|m_pr) begin
        if (m_mask == 4'hF) m_mask = 4'h0;
        m_mask = m_mask | m_pr;
      end
      if (m_pr[0]) m_a[3:0] = y;
      if (m_pr[1]) m_a[6:4] = y[2:0];
      if (m_pr[2]) m_b[3:0] = y;
      if (m_pr[3]) m_b[6:4] = y[2:0];
    end
  end

  always @(negedge clk) if (load_pulse === 1'b1) obs_pulses++;

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pb(input int idx, input logic v);
    case (idx)
      0: pb1 = v;
      1: pb2 = v;
      2: pb3 = v;
      default: pb4 = v;
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1; pb1 = 0; pb2 = 0; pb3 = 0; pb4 = 0; y = 4'h0;
    #1;
    checks++;
    if ({a, b, load_mask, operands_valid, load_pulse} !== 20'h0)
      $display("FAIL reset_async outputs=%h required=0", {a, b, load_mask, operands_valid, load_pulse});
    else passes++;
    cycles(3);
    rst = 1'b0;
    cycles(5);
    checks++;
    if ({a, b, load_mask, operands_valid, load_pulse} !== 20'h0)
      $display("FAIL reset_idle outputs=%h required=0", {a, b, load_mask, operands_valid, load_pulse});
    else passes++;
  endtask

  task automatic test_full_load;
    logic [3:0] ys[4];
    int p0;
    ys[0] = 4'h5; ys[1] = 4'h3; ys[2] = 4'hA; ys[3] = 4'h1;
    p0 = obs_pulses;
    for (int k = 0; k < 4; k++) begin
      y = ys[k];
      set_pb(k, 1'b1);
      for (int c = 0; c < 16; c++) begin
        if (c == 8) set_pb(k, 1'b0);
        @(negedge clk);
        checks++;
        if ({a, b, load_mask, load_pulse} !== {m_a, m_b, m_mask, m_pulse})
          $display("FAIL full_load_model btn=%0d cyc=%0d got=%h required=%h", k, c,
                   {a, b, load_mask, load_pulse}, {m_a, m_b, m_mask, m_pulse});
        else passes++;
      end
    end
    checks++;
    if (a !== 7'h35) $display("FAIL full_load_a got=%h required=35", a); else passes++;
    checks++;
    if (b !== 7'h1A) $display("FAIL full_load_b got=%h required=1a", b); else passes++;
    checks++;
    if (operands_valid !== 1'b1) $display("FAIL full_load_valid got=%b required=1", operands_valid); else passes++;
    checks++;
    if (obs_pulses - p0 !== 4) $display("FAIL full_load_pulses got=%0d required=4", obs_pulses - p0); else passes++;
  endtask

  task automatic test_glitch;
    logic [6:0] a0;
    logic [3:0] m0;
    int p0;
    a0 = a; m0 = load_mask; p0 = obs_pulses;
    y = 4'hC;
    pb1 = 1'b1;
    cycles(3);
    pb1 = 1'b0;
    cycles(12);
    checks++;
    if (a !== a0) $display("FAIL glitch_a got=%h required=%h", a, a0); else passes++;
    checks++;
    if (load_mask !== m0) $display("FAIL glitch_mask got=%b required=%b", load_mask, m0); else passes++;
    checks++;
    if (obs_pulses != p0) $display("FAIL glitch_pulse got=%0d required=0", obs_pulses - p0); else passes++;
  endtask

  task automatic test_latency_hold;
    int p0;
    p0 = obs_pulses;
    y = 4'h7;
    pb3 = 1'b1;
    cycles(5);
    checks++;
    if (b[3:0] !== 4'hA) $display("FAIL latency_early got=%h required=a", b[3:0]); else passes++;
    cycles(1);
    checks++;
    if (b[3:0] !== 4'h7) $display("FAIL latency_edge6 got=%h required=7", b[3:0]); else passes++;
    cycles(44);
    pb3 = 1'b0;
    cycles(10);
    checks++;
    if (obs_pulses - p0 !== 1) $display("FAIL hold_pulses got=%0d required=1", obs_pulses - p0); else passes++;
    checks++;
    if (load_mask !== m_mask) $display("FAIL hold_mask got=%b required=%b", load_mask, m_mask); else passes++;
  endtask

  task automatic test_simultaneous;
    int p0;
    p0 = obs_pulses;
    y = 4'hF;
    pb1 = 1'b1; pb3 = 1'b1;
    cycles(10);
    pb1 = 1'b0; pb3 = 1'b0;
    cycles(10);
    checks++;
    if (a[3:0] !== 4'hF || b[3:0] !== 4'hF)
      $display("FAIL simul_data got=%h/%h required=f/f", a[3:0], b[3:0]);
    else passes++;
    checks++;
    if (load_mask !== 4'b0101) $display("FAIL simul_mask got=%b required=0101", load_mask); else passes++;
    checks++;
    if (obs_pulses - p0 !== 1) $display("FAIL simul_pulses got=%0d required=1", obs_pulses - p0); else passes++;
  endtask

  task automatic test_new_set;
    logic [6:0] a0, b0;
    y = 4'h2; pb2 = 1'b1; cycles(8); pb2 = 1'b0; cycles(8);
    y = 4'h4; pb4 = 1'b1; cycles(8); pb4 = 1'b0; cycles(8);
    checks++;
    if (operands_valid !== 1'b1) $display("FAIL newset_prevalid got=%b required=1", operands_valid); else passes++;
    a0 = a; b0 = b;
    y = 4'h6; pb2 = 1'b1; cycles(8); pb2 = 1'b0; cycles(8);
    checks++;
    if (load_mask !== 4'b0010) $display("FAIL newset_mask got=%b required=0010", load_mask); else passes++;
    checks++;
    if (operands_valid !== 1'b0) $display("FAIL newset_valid got=%b required=0", operands_valid); else passes++;
    checks++;
    if (a !== {3'h6, a0[3:0]} || b !== b0)
      $display("FAIL newset_data got=%h/%h required=%h/%h", a, b, {3'h6, a0[3:0]}, b0);
    else passes++;
  endtask

  task automatic test_reset_mid_debounce;
    y = 4'h5;
    pb4 = 1'b1;
    cycles(3);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a, b, load_mask, operands_valid, load_pulse} !== 20'h0)
      $display("FAIL midrst_async outputs=%h required=0", {a, b, load_mask, operands_valid, load_pulse});
    else passes++;
    cycles(2);
    rst = 1'b0;
    cycles(5);
    checks++;
    if (b !== 7'h00) $display("FAIL midrst_early got=%h required=00", b); else passes++;
    cycles(1);
    checks++;
    if (b !== 7'h50) $display("FAIL midrst_load got=%h required=50", b); else passes++;
    checks++;
    if (load_mask !== 4'b1000) $display("FAIL midrst_mask got=%b required=1000", load_mask); else passes++;
    pb4 = 1'b0;
    cycles(10);
  endtask

  task automatic test_random;
    int left[4];
    for (int i = 0; i < 4; i++) left[i] = $urandom_range(1, 10);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        left[i]--;
        if (left[i] <= 0) begin
          case (i)
            0: pb1 = ~pb1;
            1: pb2 = ~pb2;
            2: pb3 = ~pb3;
            default: pb4 = ~pb4;
          endcase
          left[i] = $urandom_range(1, 10);
        end
      end
      if ($urandom_range(0, 7) == 0) y = 4'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if ({a, b, load_mask, operands_valid, load_pulse} !==
          {m_a, m_b, m_mask, (m_mask == 4'hF), m_pulse})
        $display("FAIL random_model cyc=%0d got=%h required=%h", c,
                 {a, b, load_mask, operands_valid, load_pulse},
                 {m_a, m_b, m_mask, (m_mask == 4'hF), m_pulse});
      else passes++;
    end
    pb1 = 0; pb2 = 0; pb3 = 0; pb4 = 0;
    cycles(10);
  endtask

  initial begin
    checks = 0; passes = 0; obs_pulses = 0;
    test_reset();
    test_full_load();
    test_glitch();
    test_latency_hold();
    test_simultaneous();
    test_new_set();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
